// File: rtl/load_store_unit_if.sv
// Bundle of the pipeline request, data-memory port and MEM/WB result signals
// of the load/store unit; the LSU uses the slave view, its environment the master view.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_read;
  logic        req_write;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] wdata;

  logic [63:0] Mem_Addr;
  logic [63:0] Write_Data;
  logic        Mem_Write;
  logic        Mem_Read;
  logic [63:0] Read_Data;

  logic        stall;
  logic [63:0] load_data;
  logic        load_valid;
  logic        fault;

  modport slave (
    input  req_valid, req_read, req_write, funct3, addr, wdata, Read_Data,
    output Mem_Addr, Write_Data, Mem_Write, Mem_Read, stall, load_data, load_valid, fault
  );

  modport master (
    output req_valid, req_read, req_write, funct3, addr, wdata, Read_Data,
    input  Mem_Addr, Write_Data, Mem_Write, Mem_Read, stall, load_data, load_valid, fault
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store controller: sized RV64 loads with extension, full-width
// stores in one cycle, and byte/half/word stores as a stalling read-modify-write.
module load_store_unit #(
  parameter int MEM_BYTES = 256
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  localparam int          AW      = $clog2(MEM_BYTES);
  localparam logic [63:0] WIN_MAX = 64'(MEM_BYTES - 8);

  typedef enum logic {IDLE, RMW_WRITE} state_e;

  state_e          state_q, state_d;
  logic [63:0]     rdata_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [1:0]      size_q;
  logic [63:0]     load_data_q, load_data_d;
  logic            load_valid_q, load_valid_d;
  logic            fault_q, fault_d;

  logic            legal, type_ok, capture_rmw;
  logic            mem_read, mem_write, stall;
  logic [63:0]     maddr, wdat;

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{56{d[7]}},  d[7:0]};
      3'b001:  return {{48{d[15]}}, d[15:0]};
      3'b010:  return {{32{d[31]}}, d[31:0]};
      3'b011:  return d;
      3'b100:  return {56'd0, d[7:0]};
      3'b101:  return {48'd0, d[15:0]};
      3'b110:  return {32'd0, d[31:0]};
      default: return 64'd0;
    endcase
  endfunction

  // Only the low 1/2/4 bytes come from the store; the rest is the old memory word.
  function automatic logic [63:0] merge(input logic [63:0] old, input logic [31:0] wd,
                                        input logic [1:0] size);
    case (size)
      2'b00:   return {old[63:8],  wd[7:0]};
      2'b01:   return {old[63:16], wd[15:0]};
      default: return {old[63:32], wd[31:0]};
    endcase
  endfunction

  always_comb begin
    type_ok = bus.req_read ? (bus.funct3 != 3'b111) : (bus.funct3[2] == 1'b0);
    legal   = bus.req_valid && (bus.req_read ^ bus.req_write) && type_ok &&
              (bus.addr <= WIN_MAX);
  end

  always_comb begin
    state_d      = state_q;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    stall        = 1'b0;
    maddr        = 64'd0;
    wdat         = 64'd0;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    fault_d      = 1'b0;
    capture_rmw  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && !legal) begin
          fault_d = 1'b1;
        end else if (legal && bus.req_read) begin
          mem_read     = 1'b1;
          maddr        = bus.addr;
          load_data_d  = extend(bus.Read_Data, bus.funct3);
          load_valid_d = 1'b1;
        end else if (legal && bus.funct3[1:0] == 2'b11) begin
          mem_write = 1'b1;
          maddr     = bus.addr;
          wdat      = bus.wdata;
        end else if (legal) begin
          mem_read    = 1'b1;
          maddr       = bus.addr;
          stall       = 1'b1;
          capture_rmw = 1'b1;
          state_d     = RMW_WRITE;
        end
      end
      RMW_WRITE: begin
        // EX/MEM is still frozen on the store here, so its inputs are ignored.
        mem_write = 1'b1;
        maddr     = 64'(addr_q);
        wdat      = merge(rdata_q, wdata_q, size_q);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are gated by reset so a pending RMW write is dropped immediately.
  assign bus.Mem_Read   = reset & mem_read;
  assign bus.Mem_Write  = reset & mem_write;
  assign bus.stall      = reset & stall;
  assign bus.Mem_Addr   = reset ? maddr : 64'd0;
  assign bus.Write_Data = reset ? wdat  : 64'd0;
  assign bus.load_data  = load_data_q;
  assign bus.load_valid = load_valid_q;
  assign bus.fault      = fault_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      load_data_q  <= 64'd0;
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      fault_q      <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture_rmw) begin
      rdata_q <= bus.Read_Data;
      addr_q  <= bus.addr[AW-1:0];
      wdata_q <= bus.wdata[31:0];
      size_q  <= bus.funct3[1:0];
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage access controller between the EX/MEM pipeline register and the byte-addressed 256-byte data memory. Translates RV64 load/store requests (funct3-sized) into the memory's fixed 8-byte little-endian read/write port. Performs sign/zero extension on loads. Implements sub-doubleword stores (sb/sh/sw) as a two-cycle read-modify-write, stalling the pipeline for one cycle. Flags out-of-range and illegal accesses instead of issuing them.

## Interface
- MEM_BYTES, 256: data memory size in bytes; legal 8-byte window base is 0..MEM_BYTES-8.
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  EX/MEM holds a memory instruction this cycle.
- req_read  in  1  instruction is a load.
- req_write  in  1  instruction is a store.
- funct3  in  3  load: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu; store: 000 sb, 001 sh, 010 sw, 011 sd.
- addr  in  64  byte address (ALU result).
- wdata  in  64  store data (rs2); low bytes used for narrow stores.
- Mem_Addr  out  64  address to data memory.
- Write_Data  out  64  8-byte write data to data memory.
- Mem_Write  out  1  write strobe; memory writes at the next rising edge.
- Mem_Read  out  1  read enable; memory Read_Data is combinational.
- Read_Data  in  64  data memory read result.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- load_data  out  64  extended load result, registered, to MEM/WB.
- load_valid  out  1  one-cycle pulse: load_data valid.
- fault  out  1  one-cycle pulse: previous-cycle request was rejected.

## Operation
- States: IDLE, RMW_WRITE. Reset → IDLE.
- Legal request: req_valid, exactly one of req_read/req_write, funct3 legal for that type (load 111 and store 1xx illegal), addr[63:8] == 0 and addr[7:0] <= MEM_BYTES-8.
- Illegal request in IDLE: no Mem_Read/Mem_Write; fault = 1 next cycle; no stall.
- Load in IDLE: Mem_Read = 1, Mem_Addr = addr (combinational). Capture at edge: load_data = extend(Read_Data), load_valid = 1. Extension: lb/lh/lw sign-extend bits 7/15/31; lbu/lhu/lwu zero-extend; ld passes 64 bits.
- sd in IDLE: Mem_Write = 1, Mem_Addr = addr, Write_Data = wdata; no stall.
- sb/sh/sw in IDLE: Mem_Read = 1, Mem_Addr = addr, stall = 1. At edge capture Read_Data, addr, wdata, funct3 → RMW_WRITE.
- RMW_WRITE: Mem_Write = 1, Mem_Addr = saved addr, Write_Data = saved read data with low 1/2/4 bytes replaced by saved wdata low bytes; stall = 0; inputs ignored (EX/MEM still shows the frozen store); → IDLE.
- Mem_Read, Mem_Write and stall are 0 whenever reset is asserted and when req_valid = 0 in IDLE. Mem_Addr and Write_Data are 0 when no strobe is active.

## Timing
- Reset values: state IDLE, load_data 0, load_valid 0, fault 0, stall 0, Mem_Read 0, Mem_Write 0, Mem_Addr 0, Write_Data 0.
- Load latency: 1 cycle (issue cycle N, load_data/load_valid at N+1).
- sd: write committed at end of issue cycle. sb/sh/sw: 2 cycles, stall high only in the first; write committed at end of the second.
- Back-to-back: a load immediately after any store observes the stored bytes (write lands on the edge before the load's cycle).
- load_valid and fault are single-cycle pulses and never assert together.
- Reset asserted in RMW_WRITE: pending write dropped, memory untouched, state → IDLE immediately.
- Upper memory bytes beyond the store width are preserved exactly by RMW.

## Test plan
- Memory byte 0 = 0x0A, lb/lbu at addr 0 -> load_data 0x000000000000000A next cycle; byte 8 = 0xF6, lb at 8 -> 0xFFFFFFFFFFFFFFF6; lbu -> 0x00000000000000F6.
- sd 0x1122334455667788 at 16, then ld 16 -> 0x1122334455667788, no stall cycles.
- After the above, sh 0xABCD at 16 -> stall 1 cycle, Mem_Write in cycle 2 with 0x112233445566ABCD; lw 16 -> 0x000000005566ABCD; lh 16 -> 0xFFFFFFFFFFFFABCD.
- ld at addr 252, lw at addr 0x100, store funct3 101, req_read&req_write -> no strobes, fault pulse next cycle, memory unchanged.
- sb 0x55 at 24 with reset pulsed low during RMW_WRITE -> Mem_Write never asserted, byte 24 keeps 0x07, all outputs 0 during reset.
- sw to 32 immediately followed by lwu at 32 -> second access sees new value; load_valid single pulse.
